fib_engine: RTL
===============

FIB_ENGINE -- requirements
Module: fib_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data/argument/result width in bits (WIDTH >= 4).
REQ-002 SHALL have parameter DEPTH, default 16, number of recursion frames held by the internal stack (DEPTH >= 2).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port start  input  1  request a new computation; sampled only in IDLE.
REQ-007 SHALL have port n_in  input  WIDTH  argument n; captured on the edge that accepts start.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking end of a job (success or error).
REQ-010 SHALL have port result  output  WIDTH  F(n) mod 2^WIDTH; valid from done until the next accepted start.
REQ-011 SHALL have port ovf  output  1  sticky per job: some addition carried out of WIDTH bits.
REQ-012 SHALL have port err  output  1  sticky per job: stack overflow abort.
REQ-013 SHALL have port sp  output  clog2(DEPTH+1)  current number of occupied stack frames.

Function
REQ-014 SHALL compute F(0)=F(1)=1, F(n)=F(n-1)+F(n-2) by explicit stack recursion, never by closed form or iteration.
REQ-015 SHALL store each stack frame as {n: WIDTH, flag: 1, acc: WIDTH}.
REQ-016 SHALL implement states IDLE, EVAL, RET, DONE, ERR, one transition per clock.
REQ-017 IDLE: start=1 -> capture cur=n_in, clear ovf, err, ret, go EVAL; start=0 -> stay.
REQ-018 EVAL, cur<2: ret<=1, go RET.
REQ-019 EVAL, cur>=2, sp<DEPTH: push {cur,0,0}, cur<=cur-1, stay EVAL.
REQ-020 EVAL, cur>=2, sp==DEPTH: no push, go ERR.
REQ-021 RET, sp==0: result<=ret, go DONE.
REQ-022 RET, top.flag==0: overwrite top in place with {top.n,1,ret} (sp unchanged), cur<=top.n-2, go EVAL.
REQ-023 RET, top.flag==1: pop, ret<=top.acc+ret (WIDTH bits, set ovf on carry-out), stay RET.
REQ-024 DONE: done=1 for this cycle only, go IDLE.
REQ-025 ERR: done=1 and err=1, result<=0, sp<=0, go IDLE; err stays high until the next accepted start.
REQ-026 Cycles from start-accept edge to the edge entering DONE SHALL be exactly 2*(2*F(n)-1), with F taken unbounded.
REQ-027 Maximum stack use for argument n SHALL be n-1 frames; n<=DEPTH+1 SHALL never raise err.
REQ-028 start while busy SHALL be ignored with no effect on the running job.
REQ-029 result, ovf, err SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, force IDLE, sp=0, busy=0, done=0, result=0, ovf=0, err=0, and invalidate all frames.
REQ-031 rst asserted mid-job SHALL abort the job with no done pulse; the first start after rst release SHALL run normally.

Verification
REQ-032 WIDTH=8, DEPTH=16, n_in=1 -> done pulses 2 cycles after start accept, result=1, ovf=0, err=0, sp=0.
REQ-033 n_in=2 -> done 6 cycles after accept, result=2; n_in=5 -> done 30 cycles after accept, result=8, max sp=4.
REQ-034 WIDTH=8, n_in=13 (F=377) -> result=121 (377 mod 256), ovf=1, err=0.
REQ-035 DEPTH=4, n_in=6 -> err=1, done pulse, result=0, sp=0; next start with n_in=5 -> result=8, err=0.
REQ-036 start re-pulsed with n_in=3 during n_in=7 job -> only one done, result=21; rst mid-job -> all outputs 0 at once, no done.

Source files
------------

// File: rtl/fib_engine.sv
// fib_engine: computes F(n) mod 2^WIDTH (F(0)=F(1)=1) by explicit stack recursion.
// Ports:
//   clk     - system clock, all state updates on the rising edge
//   rst     - asynchronous active-high reset
//   start   - request a new computation (sampled only in IDLE)
//   n_in    - argument n, captured on the edge that accepts start
//   busy    - high in every state except IDLE
//   done    - one-cycle pulse at the end of a job (success or error)
//   result  - F(n) mod 2^WIDTH, held until the next accepted start
//   ovf     - sticky per job: some addition carried out of WIDTH bits
//   err     - sticky per job: stack overflow abort
//   sp      - number of occupied stack frames
module fib_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             n_in,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             result,
    output logic                         ovf,
    output logic                         err,
    output logic [$clog2(DEPTH+1)-1:0]   sp
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, EVAL, RET, DONE, ERR} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] n;
        logic             flag;  // 0: first child pending, 1: acc holds F(n-1)
        logic [WIDTH-1:0] acc;
    } frame_t;

    state_t           state;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] ret;
    frame_t           stk [DEPTH];

    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    push_idx;
    frame_t           top;
    logic [WIDTH:0]   sum;

    // Index math is truncated to the array index width; sp is only used as a
    // push index when sp < DEPTH and as a top index when sp > 0.
    assign top_idx  = IW'(sp - SPW'(1));
    assign push_idx = IW'(sp);
    assign top      = stk[top_idx];
    assign sum      = {1'b0, top.acc} + {1'b0, ret};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cur    <= '0;
            ret    <= '0;
            sp     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stk[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur   <= n_in;
                        ovf   <= 1'b0;
                        err   <= 1'b0;
                        ret   <= '0;
                        busy  <= 1'b1;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (cur < WIDTH'(2)) begin
                        ret   <= WIDTH'(1);
                        state <= RET;
                    end else if (sp != SPW'(DEPTH)) begin
                        stk[push_idx] <= '{n: cur, flag: 1'b0, acc: '0};
                        sp            <= sp + SPW'(1);
                        cur           <= cur - WIDTH'(1);
                    end else begin
                        // done and err are visible during the ERR cycle
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= ERR;
                    end
                end
                RET: begin
                    if (sp == '0) begin
                        result <= ret;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (!top.flag) begin
                        // park F(n-1) in the frame and descend into n-2
                        stk[top_idx] <= '{n: top.n, flag: 1'b1, acc: ret};
                        cur          <= top.n - WIDTH'(2);
                        state        <= EVAL;
                    end else begin
                        ret <= sum[WIDTH-1:0];
                        if (sum[WIDTH]) ovf <= 1'b1;
                        sp  <= sp - SPW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    result <= '0;
                    sp     <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
